// File: rtl/arith_unit_pipe.sv
// arith_unit_pipe: registered S1/S2/Cin arithmetic unit with valid/ready handshake, Zero/Negative/Overflow flags
// and an optional running accumulator enabled by defining ARITH_UNIT_ACC_EN.
module arith_unit_pipe #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             S1,
   input  logic             S2,
   input  logic             Cin,
   input  logic             acc_sel,
   input  logic             acc_clr,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] F,
   output logic             Cout,
   output logic             Zero,
   output logic             Negative,
   output logic             Overflow,
   output logic [WIDTH-1:0] ACC
);
   logic [WIDTH-1:0] p, x, y, acc;
   logic [WIDTH:0]   sum;
   logic             ovf, in_fire;
   assign in_ready = !out_valid || out_ready;
   assign in_fire  = in_valid && in_ready;
`ifdef ARITH_UNIT_ACC_EN
   assign p = acc_sel ? (acc_clr ? '0 : acc) : A;
   // accumulator follows each accepted result; a clear is ignored while the output is stalled
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) acc <= '0;
      else if (in_fire) acc <= sum[WIDTH-1:0];
      else if (acc_clr && in_ready) acc <= '0;
`else
   logic unused_acc_ctl;
   assign unused_acc_ctl = acc_sel ^ acc_clr;
   assign p   = A;
   assign acc = '0;
`endif
   assign x   = S1 ? (S2 ? '0 : ~p) : p;
   assign y   = S2 ? ~B : B;
   assign sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, Cin};
   assign ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
   // single output register: loads on accept, drops valid once the consumer takes it
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         F         <= '0;
         Cout      <= 1'b0;
         Overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else if (in_fire) begin
         F         <= sum[WIDTH-1:0];
         Cout      <= sum[WIDTH];
         Overflow  <= ovf;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   assign Zero     = ~|F;
   assign Negative = F[WIDTH-1];
   assign ACC      = acc;
endmodule

// File: tb/tb_arith_unit_pipe.sv
// tb_arith_unit_pipe: directed and randomized checks of arith_unit_pipe at WIDTH=8
module tb_arith_unit_pipe;
`ifdef ARITH_UNIT_ACC_EN
   localparam bit ACC_EN = 1'b1;
`else
   localparam bit ACC_EN = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic s1 = 0, s2 = 0, cin = 0, asel = 0, aclr = 0, iv = 0, ordy = 0;
   logic in_ready, out_valid, cout, zero, neg, ovf;
   logic [7:0] f, acc;
   int checks = 0, failures = 0;

   arith_unit_pipe #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .A(a), .B(b), .S1(s1), .S2(s2), .Cin(cin),
      .acc_sel(asel), .acc_clr(aclr), .in_valid(iv), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(ordy), .F(f), .Cout(cout), .Zero(zero),
      .Negative(neg), .Overflow(ovf), .ACC(acc)
   );

   always #5 clk = ~clk;

   // reference: plain integer arithmetic on the operation table
   function automatic void calc(input int av, bv, input bit o1, o2, ci, sel, clr, input int accv,
                                output logic [7:0] fr, output logic co, output logic ov);
      int p, x, y, s, sx, sy, ss;
      p = (ACC_EN && sel) ? (clr ? 0 : accv) : av;
      case ({o1, o2})
         2'b00: begin x = p;       y = bv;       end
         2'b01: begin x = p;       y = 255 - bv; end
         2'b10: begin x = 255 - p; y = bv;       end
         default: begin x = 0;     y = 255 - bv; end
      endcase
      s  = x + y + int'(ci);
      fr = 8'(s % 256);
      co = s > 255;
      sx = x > 127 ? x - 256 : x;
      sy = y > 127 ? y - 256 : y;
      ss = sx + sy + int'(ci);
      ov = ss > 127 || ss < -128;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic setop(input int av, bv, input bit o1, o2, ci);
      a = 8'(av); b = 8'(bv); s1 = o1; s2 = o2; cin = ci;
   endtask

   task automatic test_reset();
      #12;
      cmp("reset_valid", int'(out_valid), 0);
      cmp("reset_f", int'(f), 0);
      cmp("reset_flags", int'({cout, zero, neg, ovf}), 4'b0100);
      cmp("reset_acc", int'(acc), 0);
      cmp("reset_in_ready", int'(in_ready), 1);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_vectors();
      iv = 1; ordy = 1; asel = 0; aclr = 0;
      setop(8'hF0, 8'h20, 0, 0, 0); step();
      cmp("add_f", int'(f), 8'h10);
      cmp("add_flags", int'({out_valid, cout, zero, ovf}), 4'b1100);
      setop(8'h05, 8'h05, 0, 1, 1); step();
      cmp("sub_eq_f", int'(f), 0);
      cmp("sub_eq_flags", int'({cout, zero}), 2'b11);
      setop(8'h7F, 8'hFF, 0, 1, 1); step();
      cmp("sub_ovf_f", int'(f), 8'h80);
      cmp("sub_ovf_flags", int'({ovf, neg}), 2'b11);
      setop(8'h5A, 8'h00, 1, 1, 1); step();
      cmp("neg0_f", int'({cout, f}), 9'h100);
      setop(8'h5A, 8'h0F, 1, 1, 0); step();
      cmp("notb_f", int'({cout, f}), 9'h0F0);
      iv = 0; step();
      cmp("drain_valid", int'(out_valid), 0);
      cmp("drain_hold_f", int'(f), 8'hF0);
   endtask

   task automatic test_backpressure();
      iv = 1; ordy = 0;
      setop(8'hF0, 8'h20, 0, 0, 0); step();
      cmp("bp_first", int'({out_valid, f}), 9'h110);
      for (int i = 0; i < 3; i++) begin
         setop(i + 1, 1, 0, 0, 0);
         #1;
         cmp("bp_in_ready", int'(in_ready), 0);
         step();
         cmp("bp_hold", int'({out_valid, f}), 9'h110);
      end
      ordy = 1;
      #1;
      cmp("bp_release_ready", int'(in_ready), 1);
      step();
      cmp("bp_next", int'({out_valid, f}), 9'h104);
      iv = 0; step();
      cmp("bp_once", int'({out_valid, f}), 9'h004);
   endtask

   task automatic test_acc();
      ordy = 1;
      if (ACC_EN) begin
         iv = 0; aclr = 1; step();
         cmp("acc_clear", int'(acc), 0);
         aclr = 0; iv = 1; asel = 1;
         for (int i = 1; i <= 4; i++) begin
            setop(8'hAA, 3, 0, 0, 0); step();
            cmp("acc_run", int'(acc), 3 * i);
         end
         aclr = 1; setop(8'hAA, 1, 0, 0, 0); step();
         cmp("acc_clr_fire", int'({acc, f}), 16'h0101);
      end else begin
         iv = 1; asel = 1; aclr = 1;
         setop(8'h11, 8'h22, 0, 0, 0); step();
         cmp("noacc_f", int'(f), 8'h33);
         cmp("noacc_acc", int'(acc), 0);
      end
      iv = 0; asel = 0; aclr = 0; step();
   endtask

   task automatic test_async_reset();
      iv = 1; ordy = 0;
      setop(8'h30, 8'h03, 0, 0, 0); step();
      cmp("ar_pending", int'({out_valid, f}), 9'h133);
      #2 rst_n = 1'b0;
      #1;
      cmp("ar_valid", int'(out_valid), 0);
      cmp("ar_f_zero", int'({f, zero}), 9'h001);
      cmp("ar_acc", int'(acc), 0);
      cmp("ar_in_ready", int'(in_ready), 1);
      iv = 0;
      step();
      #2 rst_n = 1'b1;
      step();
      cmp("ar_after", int'(out_valid), 0);
   endtask

   task automatic test_random();
      bit m_valid = 0, m_co = 0, m_ov = 0, rdy, fire;
      logic [7:0] m_f = 0, m_acc = 0, nf;
      logic nco, nov;
      int sent = 0, got = 0;
      for (int n = 0; n < 400; n++) begin
         setop($urandom_range(255), $urandom_range(255), 1'($urandom), 1'($urandom), 1'($urandom));
         iv = $urandom_range(9) < 7; ordy = $urandom_range(9) < 7;
         asel = 1'($urandom); aclr = $urandom_range(9) == 0;
         #1;
         rdy = !m_valid || ordy;
         cmp("rnd_in_ready", int'(in_ready), int'(rdy));
         fire = iv && rdy;
         calc(a, b, s1, s2, cin, asel, aclr, m_acc, nf, nco, nov);
         if (m_valid && ordy) got++;
         step();
         if (fire) begin
            m_f = nf; m_co = nco; m_ov = nov; m_valid = 1; sent++;
            if (ACC_EN) m_acc = nf;
         end else begin
            if (ordy) m_valid = 0;
            if (ACC_EN && aclr && rdy) m_acc = 0;
         end
         cmp("rnd_out", int'({out_valid, f, cout, zero, neg, ovf, acc}),
             int'({m_valid, m_f, m_co, m_f == 0, m_f[7], m_ov, m_acc}));
      end
      cmp("rnd_count", sent, got + int'(m_valid));
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_backpressure();
      test_acc();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
